// File: rtl/psum_drain_ctrl.sv
// Partial-sum drain controller: reads NUM_PSUM words from the GLB and streams them out
// through a 2-entry skid FIFO. Define PSUM_DRAIN_RELU_EN to clamp negative words to zero.
//
// state | meaning
// IDLE  | waiting for compute_done
// READ  | issuing GLB reads, bounded by FIFO room
// FLUSH | all reads issued, draining FIFO until the last word transfers
// DONE  | one-cycle drain_done pulse
module psum_drain_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_PSUM   = 9,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  compute_done,
  output logic                  read_req_psum,
  output logic [ADDR_WIDTH-1:0] r_addr_psum,
  input  logic [DATA_WIDTH-1:0] r_data_psum,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  drain_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CNT_W = (NUM_PSUM > 1) ? $clog2(NUM_PSUM) : 1;
  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(NUM_PSUM - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_remain;
  logic [ADDR_WIDTH-1:0] r_addr_next;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic [1:0]            r_mem_last;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_pop;
  logic [2:0]            w_pending;
  logic                  w_issue_last;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_head_q;

  assign w_pop = out_valid && out_ready;

  // Room is judged after this cycle's pop so a steady stream sustains one word per cycle.
  assign w_pending     = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign read_req_psum = (r_state == S_READ) && (w_pending < 3'd2);
  assign w_issue_last  = read_req_psum && (r_remain == '0);
  assign r_addr_psum   = read_req_psum ? r_addr_next : r_addr_hold;

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_count != 2'd0);
  assign out_last  = out_valid && r_mem_last[r_rd_ptr];

`ifdef PSUM_DRAIN_RELU_EN
  assign w_head_q = w_head[DATA_WIDTH-1] ? '0 : w_head;
`else
  assign w_head_q = w_head;
`endif

  assign out_data   = out_valid ? w_head_q : '0;
  assign busy       = (r_state != S_IDLE);
  assign drain_done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_remain        <= LAST_IDX;
      r_addr_next     <= BASE;
      r_addr_hold     <= BASE;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      r_inflight      <= read_req_psum;
      r_inflight_last <= w_issue_last;

      if (read_req_psum) begin
        r_addr_hold <= r_addr_next;
        r_addr_next <= r_addr_next + ADDR_WIDTH'(1);
        r_remain    <= r_remain - CNT_W'(1);
      end

      if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(r_inflight) - 2'(w_pop);

      case (r_state)
        S_IDLE: begin
          r_remain    <= LAST_IDX;
          r_addr_next <= BASE;
          if (compute_done) r_state <= S_READ;
        end
        S_READ:  if (w_issue_last) r_state <= S_FLUSH;
        S_FLUSH: if (w_pop && out_last) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates everything that reads it.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_mem[r_wr_ptr]      <= r_data_psum;
      r_mem_last[r_wr_ptr] <= r_inflight_last;
    end
  end

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Self-checking bench for psum_drain_ctrl: GLB memory model, randomized back-pressure,
// and a word-stream reference built directly from memory contents.
module tb_psum_drain_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 9;
  localparam int NP  = 9;
  localparam int BA  = 0;
  localparam int NPW = 4;
  localparam int BAW = 510;

  logic          clk = 1'b0;
  logic          reset;
  logic          compute_done;
  logic          read_req_psum;
  logic [AW-1:0] r_addr_psum;
  logic [DW-1:0] r_data_psum;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          drain_done;

  logic          cd_w;
  logic          rreq_w;
  logic [AW-1:0] raddr_w;
  logic [DW-1:0] rdata_w;
  logic [DW-1:0] od_w;
  logic          ov_w;
  logic          ordy_w;
  logic          ol_w;
  logic          busy_w;
  logic          done_w;

  always #5 clk = ~clk;

  psum_drain_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PSUM(NP), .BASE_ADDR(BA)) u_dut (
    .clk(clk), .reset(reset), .compute_done(compute_done),
    .read_req_psum(read_req_psum), .r_addr_psum(r_addr_psum), .r_data_psum(r_data_psum),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .drain_done(drain_done)
  );

  psum_drain_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PSUM(NPW), .BASE_ADDR(BAW)) u_dut_w (
    .clk(clk), .reset(reset), .compute_done(cd_w),
    .read_req_psum(rreq_w), .r_addr_psum(raddr_w), .r_data_psum(rdata_w),
    .out_data(od_w), .out_valid(ov_w), .out_ready(ordy_w), .out_last(ol_w),
    .busy(busy_w), .drain_done(done_w)
  );

  // GLB model: one-cycle read latency, junk on the bus when not reading.
  logic [DW-1:0] mem   [512];
  logic [DW-1:0] mem_w [512];
  always @(posedge clk) begin
    r_data_psum <= read_req_psum ? mem[r_addr_psum] : 16'($urandom);
    rdata_w     <= rreq_w ? mem_w[raddr_w] : 16'($urandom);
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int ready_mode = 0;
  int req_idx, issued, accepted, n_done = 0, w_done = 0;
  int t0, first_req, last_req, first_valid, last_word, done_cyc;
  logic [DW-1:0] first_word;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_l;
  logic [16:0]   exp_q [$];
  int            w_addrs [$];
  logic [16:0]   w_words [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [DW-1:0] ref_out(input logic [DW-1:0] w);
`ifdef PSUM_DRAIN_RELU_EN
    if ($signed(w) < 0) return '0;
`endif
    return w;
  endfunction

  task automatic sample();
    logic [16:0] e;
    if (reset) begin
      prev_stall = 1'b0;
      return;
    end
    if (read_req_psum) begin
      chk("addr", 32'(r_addr_psum), 32'((BA + req_idx) % 512));
      if (first_req < 0) first_req = cyc;
      last_req = cyc;
      req_idx++;
      issued++;
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(prev_d));
      chk("stall_last", 32'(out_last), 32'(prev_l));
    end
    if (out_valid && out_ready) begin
      chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data", 32'(out_data), 32'(e[15:0]));
        chk("last", 32'(out_last), 32'(e[16]));
      end
      accepted++;
      if (accepted == 1) first_word = out_data;
      last_word = cyc;
    end
    if (read_req_psum) chk("outstanding", 32'((issued - accepted) <= 2), 32'd1);
    if (drain_done) begin
      chk("busy_in_done", 32'(busy), 32'd1);
      n_done++;
      done_cyc = cyc;
    end
    prev_stall = out_valid && !out_ready;
    prev_d = out_data;
    prev_l = out_last;
    if (rreq_w) w_addrs.push_back(int'(raddr_w));
    if (ov_w && ordy_w) w_words.push_back({ol_w, od_w});
    if (done_w) w_done++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = (cyc % 2 == 1);
      2: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic start_drain(input bit hold);
    t0 = cyc;
    first_req = -1; last_req = -1; first_valid = -1; last_word = -1; done_cyc = -1;
    req_idx = 0; issued = 0; accepted = 0;
    exp_q.delete();
    for (int i = 0; i < NP; i++)
      exp_q.push_back({(i == NP - 1), ref_out(mem[(BA + i) % 512])});
    compute_done = 1'b1;
    tick();
    if (!hold) compute_done = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    int d0 = n_done;
    while (n_done == d0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_completes", 32'(n_done > d0), 32'd1);
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < NP; i++) mem[(BA + i) % 512] = 16'(10 * (i + 1));
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 512; i++) begin
      mem[i]   = 16'($urandom);
      mem_w[i] = 16'($urandom);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; compute_done = 1'b0; cd_w = 1'b0; out_ready = 1'b1; ordy_w = 1'b1;
    fill_rand();
    repeat (3) tick();
    chk("rst_req", 32'(read_req_psum), 32'd0);
    chk("rst_addr", 32'(r_addr_psum), 32'(BA));
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(drain_done), 32'd0);
    chk("rst_addr_w", 32'(raddr_w), 32'(BAW));
    reset = 1'b0;
    tick();

    // V1: full-speed drain timing
    fill_seq();
    ready_mode = 0;
    start_drain(1'b0);
    wait_done(40);
    chk("v1_first_req", 32'(first_req - t0), 32'd1);
    chk("v1_last_req", 32'(last_req - t0), 32'd9);
    chk("v1_first_valid", 32'(first_valid - t0), 32'd3);
    chk("v1_last_word", 32'(last_word - t0), 32'd11);
    chk("v1_done", 32'(done_cyc - t0), 32'd12);
    chk("v1_words", 32'(accepted), 32'(NP));
    chk("v1_reqs", 32'(issued), 32'(NP));
    chk("v1_busy_after", 32'(busy), 32'd0);

    // V2: alternating back-pressure
    ready_mode = 1;
    start_drain(1'b0);
    wait_done(60);
    chk("v2_words", 32'(accepted), 32'(NP));
    chk("v2_q_empty", 32'(exp_q.size()), 32'd0);

    // V3: consumer stalled for 20 cycles
    ready_mode = 2;
    out_ready = 1'b0;
    start_drain(1'b0);
    repeat (19) tick();
    chk("v3_reads", 32'(issued), 32'd2);
    chk("v3_req_low", 32'(read_req_psum), 32'd0);
    ready_mode = 0;
    wait_done(60);
    chk("v3_words", 32'(accepted), 32'(NP));
    chk("v3_q_empty", 32'(exp_q.size()), 32'd0);

    // V4: reset after the 4th transfer
    ready_mode = 0;
    start_drain(1'b0);
    k = 0;
    while (accepted < 4 && k < 40) begin
      tick();
      k++;
    end
    chk("v4_reach4", 32'(accepted), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("v4_valid", 32'(out_valid), 32'd0);
    chk("v4_busy", 32'(busy), 32'd0);
    chk("v4_req", 32'(read_req_psum), 32'd0);
    chk("v4_addr", 32'(r_addr_psum), 32'(BA));
    repeat (3) begin
      tick();
      chk("v4_quiet", 32'(out_valid), 32'd0);
    end
    start_drain(1'b0);
    wait_done(40);
    chk("v4_first_word", 32'(first_word), 32'(ref_out(16'd10)));
    chk("v4_words", 32'(accepted), 32'(NP));

    // V5: compute_done held high through the drain
    start_drain(1'b1);
    k = 0;
    while (!drain_done && k < 60) begin
      tick();
      k++;
    end
    compute_done = 1'b0;
    repeat (6) tick();
    chk("v5_reqs", 32'(issued), 32'(NP));
    chk("v5_words", 32'(accepted), 32'(NP));
    chk("v5_idle", 32'(busy), 32'd0);
    chk("v5_q_empty", 32'(exp_q.size()), 32'd0);

    // V5b: address wrap with BASE_ADDR=510, NUM_PSUM=4
    fill_rand();
    w_addrs.delete();
    w_words.delete();
    w_done = 0;
    cd_w = 1'b1;
    tick();
    cd_w = 1'b0;
    repeat (14) tick();
    chk("w_nreq", 32'(w_addrs.size()), 32'(NPW));
    chk("w_nwords", 32'(w_words.size()), 32'(NPW));
    for (int i = 0; i < NPW; i++) begin
      if (i < w_addrs.size()) chk("w_addr", 32'(w_addrs[i]), 32'((BAW + i) % 512));
      if (i < w_words.size()) begin
        chk("w_data", 32'(w_words[i][15:0]), 32'(ref_out(mem_w[(BAW + i) % 512])));
        chk("w_last", 32'(w_words[i][16]), 32'(i == NPW - 1));
      end
    end
    chk("w_done_once", 32'(w_done), 32'd1);
    chk("w_idle", 32'(busy_w), 32'd0);

    // V6: sign handling of out_data
    fill_rand();
    mem[(BA + 0) % 512] = 16'hFFF6;
    mem[(BA + 1) % 512] = 16'h0005;
    ready_mode = 0;
    start_drain(1'b0);
    wait_done(40);
    chk("v6_word0", 32'(first_word), 32'(ref_out(16'hFFF6)));
    chk("v6_words", 32'(accepted), 32'(NP));

    // Randomized data and back-pressure
    for (int r = 0; r < 4; r++) begin
      fill_rand();
      ready_mode = 3;
      start_drain(1'b0);
      wait_done(120);
      chk("rnd_words", 32'(accepted), 32'(NP));
      chk("rnd_q_empty", 32'(exp_q.size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/psum_drain_ctrl.md
PSUM_DRAIN_CTRL -- requirements
Module: psum_drain_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 16, psum word width.
- ADDR_WIDTH, 9, psum GLB address width.
- NUM_PSUM, 9, words per drain (X_dim*Y_dim).
- BASE_ADDR, 0, first GLB psum address read.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high.
- compute_done, in, 1, PE cluster finished; starts a drain when sampled high in IDLE.
- read_req_psum, out, 1, GLB psum read request.
- r_addr_psum, out, ADDR_WIDTH, GLB psum read address.
- r_data_psum, in, DATA_WIDTH, GLB read data, valid the cycle after read_req_psum.
- out_data, out, DATA_WIDTH, drained psum word.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, consumer accepts the word.
- out_last, out, 1, high with the final word of a drain.
- busy, out, 1, high in any state other than IDLE.
- drain_done, out, 1, one-cycle pulse after the last word is accepted.

Function
REQ-003 FSM states SHALL be IDLE, READ, FLUSH, DONE.
- IDLE to READ when compute_done=1.
- READ to FLUSH when the NUM_PSUM-th request issues.
- FLUSH to DONE when the last word transfers.
- DONE to IDLE after exactly one cycle.

REQ-004 compute_done SHALL be ignored outside IDLE.

REQ-005 In READ, read_req_psum SHALL assert only when (buffer occupancy + in-flight reads) < 2.

REQ-006 r_addr_psum SHALL be BASE_ADDR + issue index, with index 0..NUM_PSUM-1 and modulo 2^ADDR_WIDTH wrap. r_addr_psum SHALL hold its last value when no read is requested.

REQ-007 r_data_psum SHALL be captured into a 2-entry FIFO on the clock edge ending the cycle after a request. No returned word SHALL be dropped.

REQ-008 The FIFO head SHALL drive out_data/out_valid.
- A transfer occurs when out_valid && out_ready.
- While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.

REQ-009 Simultaneous FIFO push and pop SHALL leave occupancy unchanged. Push into a full FIFO SHALL be impossible by REQ-005.

REQ-010 out_last SHALL be high only while the head word is index NUM_PSUM-1.

REQ-011 Latency: compute_done high in cycle T (IDLE) gives:
- first read_req_psum in T+1;
- first out_valid in T+3.
With out_ready held high, one word SHALL transfer per cycle thereafter.

REQ-012 drain_done SHALL pulse in the DONE cycle. busy SHALL be low in that same cycle only if the FSM is back in IDLE, so busy is high during DONE.

REQ-013 NUM_PSUM=1 SHALL work: one request, out_last on the first word.

Reset
REQ-014 While reset=1 at a clock edge, the block SHALL clear to:
- FSM = IDLE;
- FIFO and in-flight tracking flushed;
- read_req_psum=0, r_addr_psum=BASE_ADDR, out_valid=0, out_last=0, out_data=0, busy=0, drain_done=0.

REQ-015 Reset mid-drain SHALL discard buffered and in-flight data. A r_data_psum return arriving in the cycle after reset deasserts SHALL NOT be captured.

Configuration
REQ-016 Macro PSUM_DRAIN_RELU_EN:
- Defined: out_data SHALL be 0 when the head word's MSB (signed, two's complement) is 1, else the word unchanged.
- Undefined: out_data SHALL be the raw GLB word.
- The macro SHALL NOT affect timing or handshake.

Verification
REQ-017 The bench SHALL cover:
- V1: GLB psum[0..8]=10,20,..,90; out_ready=1; compute_done pulse at T -> read_req T+1..T+9; outputs 10..90 on T+3..T+11; out_last with 90; drain_done at T+12.
- V2: same data; out_ready low on every other cycle -> all 9 words delivered in order, none duplicated; data stable while stalled; read_req never leaves occupancy+in-flight above 2.
- V3: out_ready=0 for 20 cycles after start -> exactly 2 reads issued, then read_req stays low; on release, 9 words in order.
- V4: reset asserted after the 4th word transfers -> next cycle out_valid=0, busy=0; a new compute_done restarts from BASE_ADDR with the first word 10.
- V5: compute_done held high through the drain -> exactly one drain of 9 words (re-trigger only once back in IDLE); BASE_ADDR=510 with NUM_PSUM=4 -> addresses 510,511,0,1.
- V6: with PSUM_DRAIN_RELU_EN defined, psum[0]=16'hFFF6 (-10) -> out_data 0; psum[1]=16'h0005 -> 5. Undefined -> 16'hFFF6 passes unchanged.
